// File: rtl/ram_arb_pkg.sv
// Shared types for the scalar data-RAM port arbiter: FSM states, the
// read-return owner tag, and the burst length decode.
package ram_arb_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_t;

    // Who issued the read whose data appears on ram_q this cycle.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } owner_t;

    // A length field of zero stands for the longest burst.
    function automatic int unsigned eff_burst_len(input int unsigned len,
                                                  input int unsigned max_burst);
        return (len == 0) ? max_burst : len;
    endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// Arbiter sharing RAM port a between the CPU memory stage and the DMA engine.
// The CPU wins by default. The DMA takes over when the CPU is quiet, or after
// the CPU has been served STARVE_LIMIT cycles in a row with the DMA waiting.
// A granted burst runs to completion and cannot be pre-empted.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | CPU owns the port; a DMA grant may be issued here
// BURST | DMA owns the port, one beat per cycle, CPU stalled
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    output logic                         cpu_stall,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_rvalid,
    input  logic                         dma_req,
    input  logic                         dma_we,
    input  logic [ADDR_W-1:0]            dma_addr,
    input  logic [$clog2(MAX_BURST)-1:0] dma_len,
    input  logic [DATA_W-1:0]            dma_wdata,
    output logic                         dma_gnt,
    output logic                         dma_beat,
    output logic [DATA_W-1:0]            dma_rdata,
    output logic                         dma_rvalid,
    output logic                         dma_done,
    output logic [ADDR_W-1:0]            ram_address,
    output logic [DATA_W-1:0]            ram_data,
    output logic                         ram_wren,
    input  logic [DATA_W-1:0]            ram_q
);

    localparam int unsigned LEN_W    = $clog2(MAX_BURST);
    localparam int unsigned CNT_W    = LEN_W + 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_t          state;
    owner_t              rd_owner;
    logic [STARVE_W-1:0] starve_cnt;
    logic [CNT_W-1:0]    beats_left;
    logic [ADDR_W-1:0]   burst_addr;
    logic                burst_we;
    logic                dma_win;
    logic                cpu_win;
    logic                last_beat;

    // DMA takes the port from IDLE when the CPU is idle or has starved it long enough.
    assign dma_win   = (state == IDLE) && dma_req &&
                       (!cpu_req || (starve_cnt == STARVE_MAX));
    assign cpu_win   = (state == IDLE) && cpu_req && !dma_win;
    assign last_beat = (state == BURST) && (beats_left == CNT_W'(1));

    assign cpu_rdata  = ram_q;
    assign dma_rdata  = ram_q;
    assign cpu_rvalid = (rd_owner == OWN_CPU);
    assign dma_rvalid = (rd_owner == OWN_DMA);

    // Port mux, grant and stall; held quiet while reset is asserted.
    always_comb begin
        cpu_stall   = 1'b0;
        dma_gnt     = 1'b0;
        dma_beat    = 1'b0;
        ram_address = '0;
        ram_data    = '0;
        ram_wren    = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (dma_win) begin
                        dma_gnt   = 1'b1;
                        cpu_stall = cpu_req;
                    end else if (cpu_req) begin
                        ram_address = cpu_addr;
                        ram_data    = cpu_wdata;
                        ram_wren    = cpu_we;
                    end
                end
                BURST: begin
                    ram_address = burst_addr;
                    ram_data    = dma_wdata;
                    ram_wren    = burst_we;
                    dma_beat    = 1'b1;
                    cpu_stall   = cpu_req;
                end
                default: begin
                    cpu_stall = cpu_req;
                end
            endcase
        end
    end

    // FSM: latch burst parameters on grant, walk the beats, tag read returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            beats_left <= '0;
            burst_addr <= '0;
            burst_we   <= 1'b0;
            rd_owner   <= OWN_NONE;
            dma_done   <= 1'b0;
        end else begin
            rd_owner <= OWN_NONE;
            dma_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dma_win) begin
                        state      <= BURST;
                        burst_addr <= dma_addr;
                        burst_we   <= dma_we;
                        beats_left <= CNT_W'(eff_burst_len(32'(dma_len), MAX_BURST));
                    end else if (cpu_win && !cpu_we) begin
                        rd_owner <= OWN_CPU;
                    end
                end
                BURST: begin
                    burst_addr <= burst_addr + ADDR_W'(1);
                    beats_left <= beats_left - CNT_W'(1);
                    if (!burst_we) begin
                        rd_owner <= OWN_DMA;
                    end
                    if (last_beat) begin
                        state    <= IDLE;
                        dma_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Starvation counter: consecutive CPU wins while the DMA is waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!dma_req || dma_win) begin
            starve_cnt <= '0;
        end else if (cpu_win && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_ram_port_arbiter;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 8;
    localparam int MAX_BURST    = 16;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dma_req, dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [3:0]        dma_len;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt, dma_beat, dma_rvalid, dma_done;
    logic [DATA_W-1:0] dma_rdata;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem [0:65535];

    ram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAX_BURST(MAX_BURST), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_beat(dma_beat),
        .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_done(dma_done),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered address (one-cycle read latency).
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h1234; cpu_wdata = 8'hAB;
        dma_req = 1; dma_we = 1; dma_addr = 16'h2222; dma_len = 4'd3;
        @(negedge clk);
        checks++;
        if ({cpu_stall, dma_gnt, dma_beat, cpu_rvalid, dma_rvalid, dma_done, ram_wren} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 0000000",
                     {cpu_stall, dma_gnt, dma_beat, cpu_rvalid, dma_rvalid, dma_done, ram_wren});
        end
        checks++;
        if (ram_address !== 16'h0 || ram_data !== 8'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr %h data %h, expected 0000 00", ram_address, ram_data);
        end
        idle_inputs();
        next_cycle();
        reset = 0;
    endtask

    task automatic test_cpu_only();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 8'h5A;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 0 || ram_wren !== 1 || ram_address !== 16'h0010 || ram_data !== 8'h5A) begin
            errors++;
            $display("FAIL cpu_write: got stall %b wren %b addr %h data %h, expected 0 1 0010 5a",
                     cpu_stall, ram_wren, ram_address, ram_data);
        end
        next_cycle();
        cpu_we = 0;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 0 || ram_wren !== 0 || ram_address !== 16'h0010 || cpu_rvalid !== 0) begin
            errors++;
            $display("FAIL cpu_read_issue: got stall %b wren %b addr %h rvalid %b, expected 0 0 0010 0",
                     cpu_stall, ram_wren, ram_address, cpu_rvalid);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1 || cpu_rdata !== 8'h5A || ram_wren !== 0) begin
            errors++;
            $display("FAIL cpu_read_return: got rvalid %b rdata %h wren %b, expected 1 5a 0",
                     cpu_rvalid, cpu_rdata, ram_wren);
        end
        next_cycle();
    endtask

    task automatic test_dma_write();
        dma_req = 1; dma_we = 1; dma_addr = 16'h0100; dma_len = 4'd4;
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1 || dma_beat !== 0 || ram_wren !== 0) begin
            errors++;
            $display("FAIL dmaw_gnt: got gnt %b beat %b wren %b, expected 1 0 0", dma_gnt, dma_beat, ram_wren);
        end
        next_cycle();
        dma_req = 0;
        for (int i = 0; i < 4; i++) begin
            dma_wdata = 8'(i + 1);
            @(negedge clk);
            checks++;
            if (dma_beat !== 1 || ram_wren !== 1 || ram_address !== 16'h0100 + 16'(i) ||
                ram_data !== 8'(i + 1) || dma_done !== 0) begin
                errors++;
                $display("FAIL dmaw_beat%0d: got beat %b wren %b addr %h data %h done %b, expected 1 1 %h %h 0",
                         i, dma_beat, ram_wren, ram_address, ram_data, dma_done, 16'h0100 + 16'(i), 8'(i + 1));
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (dma_done !== 1 || dma_beat !== 0 || dma_rvalid !== 0) begin
            errors++;
            $display("FAIL dmaw_done: got done %b beat %b rvalid %b, expected 1 0 0", dma_done, dma_beat, dma_rvalid);
        end
        next_cycle();
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) begin
                cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100 + 16'(k);
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (cpu_rvalid !== 1 || cpu_rdata !== 8'(k)) begin
                    errors++;
                    $display("FAIL dmaw_readback%0d: got rvalid %b rdata %h, expected 1 %h",
                             k - 1, cpu_rvalid, cpu_rdata, 8'(k));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_contention();
        logic e_gnt, e_beat, e_stall, e_done, e_rv, prev_served;
        prev_served = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0200;
        dma_req = 1; dma_we = 1; dma_addr = 16'h0300; dma_len = 4'd4;
        for (int c = 0; c <= 18; c++) begin
            dma_wdata = 8'(c);
            e_gnt   = (c == 4) || (c == 13);
            e_beat  = (c >= 5 && c <= 8) || (c >= 14 && c <= 17);
            e_stall = (c >= 4 && c <= 8) || (c >= 13 && c <= 17);
            e_done  = (c == 9) || (c == 18);
            e_rv    = prev_served;
            @(negedge clk);
            checks++;
            if ({cpu_stall, dma_gnt, dma_beat, dma_done, cpu_rvalid} !== {e_stall, e_gnt, e_beat, e_done, e_rv}) begin
                errors++;
                $display("FAIL contention_c%0d: got stall/gnt/beat/done/rv %b, expected %b",
                         c, {cpu_stall, dma_gnt, dma_beat, dma_done, cpu_rvalid},
                         {e_stall, e_gnt, e_beat, e_done, e_rv});
            end
            prev_served = !e_stall;
            next_cycle();
            if (e_gnt) dma_req = 0;
            if (c == 5) dma_req = 1;
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_wrap();
        logic [15:0] e_addr;
        dma_req = 1; dma_we = 1; dma_addr = 16'hFFFE; dma_len = 4'd0;
        for (int c = 0; c <= 17; c++) begin
            dma_wdata = 8'(c);
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (dma_gnt !== 1 || dma_beat !== 0) begin
                    errors++;
                    $display("FAIL wrap_gnt: got gnt %b beat %b, expected 1 0", dma_gnt, dma_beat);
                end
            end else if (c <= 16) begin
                e_addr = 16'hFFFE + 16'(c - 1);
                checks++;
                if (dma_beat !== 1 || ram_address !== e_addr || ram_wren !== 1 || dma_done !== 0) begin
                    errors++;
                    $display("FAIL wrap_beat%0d: got beat %b addr %h wren %b done %b, expected 1 %h 1 0",
                             c - 1, dma_beat, ram_address, ram_wren, dma_done, e_addr);
                end
            end else begin
                checks++;
                if (dma_done !== 1 || dma_beat !== 0) begin
                    errors++;
                    $display("FAIL wrap_done: got done %b beat %b, expected 1 0", dma_done, dma_beat);
                end
            end
            next_cycle();
            dma_req = 0;
        end
        idle_inputs();
    endtask

    task automatic test_dma_read();
        dma_req = 1; dma_we = 0; dma_addr = 16'h0100; dma_len = 4'd4;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (dma_gnt !== (c == 0) || dma_beat !== (c >= 1 && c <= 4) || ram_wren !== 0 ||
                dma_rvalid !== (c >= 2) || dma_done !== (c == 5)) begin
                errors++;
                $display("FAIL dmar_ctrl_c%0d: got gnt %b beat %b wren %b rvalid %b done %b",
                         c, dma_gnt, dma_beat, ram_wren, dma_rvalid, dma_done);
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (ram_address !== 16'h0100 + 16'(c - 1)) begin
                    errors++;
                    $display("FAIL dmar_addr%0d: got %h, expected %h", c - 1, ram_address, 16'h0100 + 16'(c - 1));
                end
            end
            if (c >= 2) begin
                checks++;
                if (dma_rdata !== 8'(c - 1)) begin
                    errors++;
                    $display("FAIL dmar_data%0d: got %h, expected %h", c - 2, dma_rdata, 8'(c - 1));
                end
            end
            next_cycle();
            dma_req = 0;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        int stray;
        dma_req = 1; dma_we = 0; dma_addr = 16'h0100; dma_len = 4'd8;
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1) begin
            errors++;
            $display("FAIL rstmid_gnt: got %b, expected 1", dma_gnt);
        end
        next_cycle();
        dma_req = 0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (dma_beat !== 1 || ram_address !== 16'h0102 || dma_rvalid !== 1) begin
            errors++;
            $display("FAIL rstmid_beat2: got beat %b addr %h rvalid %b, expected 1 0102 1",
                     dma_beat, ram_address, dma_rvalid);
        end
        #1 reset = 1;
        #1;
        checks++;
        if ({cpu_stall, dma_gnt, dma_beat, cpu_rvalid, dma_rvalid, dma_done, ram_wren} !== 7'b0 ||
            ram_address !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got ctrl %b addr %h, expected 0000000 0000",
                     {cpu_stall, dma_gnt, dma_beat, cpu_rvalid, dma_rvalid, dma_done, ram_wren}, ram_address);
        end
        next_cycle();
        next_cycle();
        reset = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 0 || ram_address !== 16'h0010 || dma_beat !== 0 || dma_done !== 0) begin
            errors++;
            $display("FAIL rstmid_cpu_first: got stall %b addr %h beat %b done %b, expected 0 0010 0 0",
                     cpu_stall, ram_address, dma_beat, dma_done);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1 || cpu_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL rstmid_cpu_rdata: got rvalid %b rdata %h, expected 1 5a", cpu_rvalid, cpu_rdata);
        end
        stray = 0;
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            @(negedge clk);
            if (dma_done || dma_rvalid || dma_beat) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL rstmid_no_done: got %0d cycles with dma activity, expected 0", stray);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] bq[$];
        logic [DATA_W-1:0] shadow [int];
        logic              m_we = 0, m_cpu_rv = 0, m_dma_rv = 0, m_done = 0, m_rd_known = 0;
        logic [DATA_W-1:0] m_rd = '0;
        int                streak = 0;
        logic              dma_pend = 0;
        logic              e_gnt, e_beat, e_wren, e_stall, e_acc;
        logic [ADDR_W-1:0] e_addr, popped;
        logic [DATA_W-1:0] e_data;
        int                eff;
        for (int t = 0; t < 800; t++) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 16'h0800 + 16'($urandom_range(0, 31));
            cpu_wdata = 8'($urandom);
            if (!dma_pend && $urandom_range(0, 5) == 0) begin
                dma_pend = 1;
                dma_we   = 1'($urandom_range(0, 1));
                dma_addr = 16'h0800 + 16'($urandom_range(0, 31));
                dma_len  = 4'($urandom);
            end
            dma_req   = dma_pend;
            dma_wdata = 8'($urandom);

            e_gnt = 0; e_beat = 0; e_wren = 0; e_stall = 0; e_acc = 0; e_addr = '0; e_data = '0;
            if (bq.size() != 0) begin
                e_beat = 1; e_stall = cpu_req; e_acc = 1;
                e_addr = bq[0]; e_wren = m_we; e_data = dma_wdata;
            end else if (dma_req && (!cpu_req || streak == STARVE_LIMIT)) begin
                e_gnt = 1; e_stall = cpu_req;
            end else if (cpu_req) begin
                e_acc = 1; e_addr = cpu_addr; e_wren = cpu_we; e_data = cpu_wdata;
            end

            @(negedge clk);
            checks++;
            if ({cpu_stall, dma_gnt, dma_beat, ram_wren, cpu_rvalid, dma_rvalid, dma_done} !==
                {e_stall, e_gnt, e_beat, e_wren, m_cpu_rv, m_dma_rv, m_done}) begin
                errors++;
                $display("FAIL rand_ctrl t=%0d: got stall/gnt/beat/wren/crv/drv/done %b, expected %b", t,
                         {cpu_stall, dma_gnt, dma_beat, ram_wren, cpu_rvalid, dma_rvalid, dma_done},
                         {e_stall, e_gnt, e_beat, e_wren, m_cpu_rv, m_dma_rv, m_done});
            end
            if (e_acc) begin
                checks++;
                if (ram_address !== e_addr) begin
                    errors++;
                    $display("FAIL rand_addr t=%0d: got %h, expected %h", t, ram_address, e_addr);
                end
            end
            if (e_wren) begin
                checks++;
                if (ram_data !== e_data) begin
                    errors++;
                    $display("FAIL rand_wdata t=%0d: got %h, expected %h", t, ram_data, e_data);
                end
            end
            if ((m_cpu_rv || m_dma_rv) && m_rd_known) begin
                checks++;
                if (cpu_rdata !== m_rd || dma_rdata !== m_rd) begin
                    errors++;
                    $display("FAIL rand_rdata t=%0d: got cpu %h dma %h, expected %h", t, cpu_rdata, dma_rdata, m_rd);
                end
            end

            m_cpu_rv = 0; m_dma_rv = 0; m_done = 0; m_rd_known = 0;
            if (e_acc) begin
                if (e_wren) begin
                    shadow[int'(e_addr)] = e_data;
                end else begin
                    if (e_beat) m_dma_rv = 1;
                    else        m_cpu_rv = 1;
                    m_rd_known = shadow.exists(int'(e_addr));
                    if (m_rd_known) m_rd = shadow[int'(e_addr)];
                end
            end
            if (e_beat) begin
                popped = bq.pop_front();
                if (bq.size() == 0) m_done = 1;
                if (!dma_req) streak = 0;
            end else if (e_gnt) begin
                streak = 0;
                m_we = dma_we;
                eff = (dma_len == 0) ? MAX_BURST : int'(dma_len);
                for (int k = 0; k < eff; k++) bq.push_back(dma_addr + 16'(k));
                dma_pend = 0;
            end else if (cpu_req) begin
                streak = dma_req ? ((streak < STARVE_LIMIT) ? streak + 1 : streak) : 0;
            end else begin
                streak = 0;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        #2;
        test_reset();
        test_cpu_only();
        test_dma_write();
        test_contention();
        test_wrap();
        test_dma_read();
        test_reset_mid_burst();
        next_cycle();
        test_random();
        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the scalar data-RAM port (port a: address, data, wren, q) between two requesters: the CPU memory stage and a DMA engine (image loader / display readout).
- Sits between the Execute-Memory pipeline register and the RAM.
- The CPU has default priority. The DMA gets non-preemptible bursts, with anti-starvation protection.
- While the DMA owns the port, the arbiter stalls the CPU.

Parameters:
- ADDR_W, 16: RAM address width.
- DATA_W, 8: RAM data width.
- MAX_BURST, 16: maximum DMA burst length in beats (power of two).
- STARVE_LIMIT, 4: number of consecutive CPU-served cycles with DMA pending before the DMA is forced in.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- cpu_req  in  1  CPU memory-stage access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_stall  out  1  CPU request not served this cycle; pipeline must hold
- cpu_rdata  out  DATA_W  read data (ram_q passthrough)
- cpu_rvalid  out  1  cpu_rdata valid (cycle after read issued)
- dma_req  in  1  burst request, held until dma_gnt
- dma_we  in  1  burst direction
- dma_addr  in  ADDR_W  burst base address
- dma_len  in  $clog2(MAX_BURST)  beats; 0 encodes MAX_BURST
- dma_wdata  in  DATA_W  write data for the current beat
- dma_gnt  out  1  one-cycle pulse: burst accepted, parameters latched
- dma_beat  out  1  beat issued this cycle (DMA supplies next dma_wdata)
- dma_rdata  out  DATA_W  read data (ram_q passthrough)
- dma_rvalid  out  1  dma_rdata valid
- dma_done  out  1  one-cycle pulse, cycle after the last beat
- ram_address  out  ADDR_W  to RAM address_a
- ram_data  out  DATA_W  to RAM data_a
- ram_wren  out  1  to RAM wren_a
- ram_q  in  DATA_W  from RAM q_a (registered address, 1-cycle read latency)

Behaviour:
- Reset: state=IDLE, starve_cnt=0, beat counter=0. All outputs 0 (stall, gnt, beat, rvalids, done, ram_wren, ram_address, ram_data).
- Reset mid-burst: the burst is abandoned, no dma_done is produced, and any pending rvalid is dropped.
- The state register is sequential. Grant and RAM drive are combinational from state and requests. rvalid and done are registered.
- IDLE:
  - Forced case: dma_req=1 and (cpu_req=0 or starve_cnt==STARVE_LIMIT). Pulse dma_gnt. Latch base, len, and we. Go to BURST. No RAM access this cycle. cpu_stall=cpu_req.
  - Otherwise, if cpu_req=1: drive ram_address=cpu_addr, ram_data=cpu_wdata, ram_wren=cpu_we. cpu_stall=0.
  - If neither applies, drive ram_wren=0.
- BURST:
  - Beat i (0..len-1) drives ram_address=base+i (modulo 2^ADDR_W), ram_wren=latched we, ram_data=dma_wdata, and dma_beat=1.
  - cpu_stall=cpu_req for every BURST cycle.
  - After beat len-1, go to IDLE. The next cycle, dma_done=1.
  - The first IDLE cycle after a burst serves the CPU if cpu_req=1, even if dma_req is already high again (starve_cnt was cleared).
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, in each IDLE cycle where the CPU is served while dma_req=1.
  - Clears on dma_gnt or when dma_req=0.
- Read return:
  - A CPU read issued in cycle t gives cpu_rvalid=1 in cycle t+1.
  - A DMA read beat issued in cycle t gives dma_rvalid=1 in cycle t+1.
  - For a DMA read, the last dma_rvalid coincides with dma_done.
  - Writes never raise rvalid.
- Throughput: a burst of len N occupies N+1 cycles (the gnt cycle plus N beats).
- Fairness bound: the CPU is stalled for at most MAX_BURST+1 cycles per burst.
- dma_req may change during BURST; it is sampled only in IDLE.

Decomposition:
- Package ram_arb_pkg holds:
  - state enum {IDLE, BURST};
  - owner enum {OWN_NONE, OWN_CPU, OWN_DMA} for the rvalid tag;
  - a function computing the effective burst length (0→MAX_BURST).
- Sub-module: none. The address generator and counter stay inline.

Test Plan:
- CPU-only: write 0x5A to 0x0010, then read 0x0010. Expect cpu_stall=0 throughout, ram_wren=1 for one cycle, cpu_rvalid=1 with cpu_rdata=0x5A one cycle after the read.
- DMA-only write burst: base 0x0100, len 4, data 1..4. Expect dma_gnt, then 4 dma_beat cycles at 0x0100..0x0103, then dma_done; CPU reads back 1..4.
- Contention: cpu_req held high and dma_req raised. Expect the CPU served 4 cycles (STARVE_LIMIT), then dma_gnt with cpu_stall=1 for len+1 cycles, then the CPU resumes.
- Wrap and len encoding: base 0xFFFE, len=0. Expect 16 beats, addresses 0xFFFE, 0xFFFF, 0x0000..0x000D, then dma_done.
- DMA read burst: base 0x0100, len 4. Expect dma_rvalid on 4 consecutive cycles with data 1..4, the last coinciding with dma_done.
- Reset at beat 2 of an 8-beat burst: all outputs 0 immediately, no dma_done. After release, a CPU read is served in the first cycle.
